// File: rtl/cfg_ro_pkg.sv
// Shared types and constants for the read-mostly config space responder.
package cfg_ro_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BAR_W  = 64;
  localparam int unsigned DW_W   = ADDR_W - 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_BAR0_LO = 12'h010;
  localparam logic [ADDR_W-1:0] ADDR_BAR0_HI = 12'h014;
  localparam logic [ADDR_W-1:0] ADDR_BAR1_LO = 12'h018;
  localparam logic [ADDR_W-1:0] ADDR_BAR1_HI = 12'h01C;
  localparam logic [ADDR_W-1:0] ADDR_BAR2_LO = 12'h020;
  localparam logic [ADDR_W-1:0] ADDR_BAR2_HI = 12'h024;
  localparam logic [ADDR_W-1:0] ADDR_SUBSYS  = 12'h02C;
  localparam logic [ADDR_W-1:0] ADDR_EXP_ROM = 12'h030;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              bad;
  } rsp_t;

  // Low BAR dword: masked base with the 64-bit memory type and prefetch flag in [3:0].
  function automatic logic [DATA_W-1:0] bar_lo_word(input logic [DATA_W-1:0] base_lo,
                                                    input logic [DATA_W-1:0] size_lo,
                                                    input logic              pf);
    return (base_lo & size_lo & 32'hFFFF_FFF0) | {28'b0, pf, 2'b10, 1'b0};
  endfunction

endpackage

// File: rtl/cfg_ro_responder_if.sv
// Config write, read request and read response channels of the responder.
interface cfg_ro_responder_if;

  logic                              cfg_wr_valid;
  logic [cfg_ro_pkg::ADDR_W-1:0]     cfg_wr_addr;
  logic [cfg_ro_pkg::DATA_W-1:0]     cfg_wr_data;
  logic                              cfg_rd_valid;
  logic [cfg_ro_pkg::ADDR_W-1:0]     cfg_rd_addr;
  logic                              cfg_rd_ready;
  logic                              rsp_valid;
  logic [cfg_ro_pkg::DATA_W-1:0]     rsp_data;
  logic                              rsp_bad;
  logic                              rsp_ready;

  modport master (
    output cfg_wr_valid, cfg_wr_addr, cfg_wr_data,
    output cfg_rd_valid, cfg_rd_addr, rsp_ready,
    input  cfg_rd_ready, rsp_valid, rsp_data, rsp_bad
  );

  modport slave (
    input  cfg_wr_valid, cfg_wr_addr, cfg_wr_data,
    input  cfg_rd_valid, cfg_rd_addr, rsp_ready,
    output cfg_rd_ready, rsp_valid, rsp_data, rsp_bad
  );

endinterface

// File: rtl/cfg_bar_reg.sv
// One 64-bit BAR base register with dword write enables and size-masked readback.
module cfg_bar_reg
  import cfg_ro_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [BAR_W-1:0]  size,
  input  logic              pf,
  input  logic              wr_lo,
  input  logic              wr_hi,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_lo_c,
  output logic [DATA_W-1:0] rd_hi_c
);

  logic [BAR_W-1:0] base_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      base_q <= '0;
    end else begin
      if (wr_lo) base_q[DATA_W-1:0]     <= wr_data;
      if (wr_hi) base_q[BAR_W-1:DATA_W] <= wr_data;
    end
  end

  assign rd_lo_c = bar_lo_word(base_q[DATA_W-1:0], size[DATA_W-1:0], pf);
  assign rd_hi_c = base_q[BAR_W-1:DATA_W] & size[BAR_W-1:DATA_W];

endmodule

// File: rtl/cfg_ro_responder.sv
// Config space responder: three writable BAR bases plus read-only IDs, DSN and TL version,
// served through an accept -> decode -> response FSM.
module cfg_ro_responder
  import cfg_ro_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DSN_BASE = 12'h100,
  parameter logic [ADDR_W-1:0] OTL_BASE = 12'h200
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [BAR_W-1:0]  bar0_size,
  input  logic [BAR_W-1:0]  bar1_size,
  input  logic [BAR_W-1:0]  bar2_size,
  input  logic              bar0_pf,
  input  logic              bar1_pf,
  input  logic              bar2_pf,
  input  logic [DATA_W-1:0] exp_rom_bar,
  input  logic [15:0]       subsys_id,
  input  logic [15:0]       subsys_vendor_id,
  input  logic [BAR_W-1:0]  dsn,
  input  logic [7:0]        tl_major,
  input  logic [7:0]        tl_minor,
  cfg_ro_responder_if.slave bus
);

  localparam logic [ADDR_W-1:0] DSN_LO_ADDR = DSN_BASE + 12'h004;
  localparam logic [ADDR_W-1:0] DSN_HI_ADDR = DSN_BASE + 12'h008;

  state_t            state_q, state_d;
  logic [DW_W-1:0]   rd_dw_q, rd_dw_d;
  logic              rd_ready_q, rd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  rsp_t              rsp_q, rsp_d, rd_word;

  logic [DW_W-1:0]   wr_dw;
  logic [DATA_W-1:0] bar0_lo, bar0_hi, bar1_lo, bar1_hi, bar2_lo, bar2_hi;
  logic              accept;
  logic              unused_addr_lsbs;

  // Decoding is per dword, so the byte-lane bits are intentionally dropped.
  assign unused_addr_lsbs = ^{bus.cfg_wr_addr[1:0], bus.cfg_rd_addr[1:0]};
  assign wr_dw = bus.cfg_wr_addr[ADDR_W-1:2];

  cfg_bar_reg u_bar0 (
    .clock   (clock),
    .reset   (reset),
    .size    (bar0_size),
    .pf      (bar0_pf),
    .wr_lo   (bus.cfg_wr_valid && (wr_dw == ADDR_BAR0_LO[ADDR_W-1:2])),
    .wr_hi   (bus.cfg_wr_valid && (wr_dw == ADDR_BAR0_HI[ADDR_W-1:2])),
    .wr_data (bus.cfg_wr_data),
    .rd_lo_c (bar0_lo),
    .rd_hi_c (bar0_hi)
  );

  cfg_bar_reg u_bar1 (
    .clock   (clock),
    .reset   (reset),
    .size    (bar1_size),
    .pf      (bar1_pf),
    .wr_lo   (bus.cfg_wr_valid && (wr_dw == ADDR_BAR1_LO[ADDR_W-1:2])),
    .wr_hi   (bus.cfg_wr_valid && (wr_dw == ADDR_BAR1_HI[ADDR_W-1:2])),
    .wr_data (bus.cfg_wr_data),
    .rd_lo_c (bar1_lo),
    .rd_hi_c (bar1_hi)
  );

  cfg_bar_reg u_bar2 (
    .clock   (clock),
    .reset   (reset),
    .size    (bar2_size),
    .pf      (bar2_pf),
    .wr_lo   (bus.cfg_wr_valid && (wr_dw == ADDR_BAR2_LO[ADDR_W-1:2])),
    .wr_hi   (bus.cfg_wr_valid && (wr_dw == ADDR_BAR2_HI[ADDR_W-1:2])),
    .wr_data (bus.cfg_wr_data),
    .rd_lo_c (bar2_lo),
    .rd_hi_c (bar2_hi)
  );

  // Read map for the latched dword address; unmapped dwords answer zero with bad set.
  always_comb begin
    rd_word = '{data: '0, bad: 1'b1};
    if      (rd_dw_q == ADDR_BAR0_LO[ADDR_W-1:2]) rd_word = '{data: bar0_lo, bad: 1'b0};
    else if (rd_dw_q == ADDR_BAR0_HI[ADDR_W-1:2]) rd_word = '{data: bar0_hi, bad: 1'b0};
    else if (rd_dw_q == ADDR_BAR1_LO[ADDR_W-1:2]) rd_word = '{data: bar1_lo, bad: 1'b0};
    else if (rd_dw_q == ADDR_BAR1_HI[ADDR_W-1:2]) rd_word = '{data: bar1_hi, bad: 1'b0};
    else if (rd_dw_q == ADDR_BAR2_LO[ADDR_W-1:2]) rd_word = '{data: bar2_lo, bad: 1'b0};
    else if (rd_dw_q == ADDR_BAR2_HI[ADDR_W-1:2]) rd_word = '{data: bar2_hi, bad: 1'b0};
    else if (rd_dw_q == ADDR_SUBSYS[ADDR_W-1:2])
      rd_word = '{data: {subsys_id, subsys_vendor_id}, bad: 1'b0};
    else if (rd_dw_q == ADDR_EXP_ROM[ADDR_W-1:2]) rd_word = '{data: exp_rom_bar, bad: 1'b0};
    else if (rd_dw_q == DSN_LO_ADDR[ADDR_W-1:2])  rd_word = '{data: dsn[31:0], bad: 1'b0};
    else if (rd_dw_q == DSN_HI_ADDR[ADDR_W-1:2])  rd_word = '{data: dsn[63:32], bad: 1'b0};
    else if (rd_dw_q == OTL_BASE[ADDR_W-1:2])
      rd_word = '{data: {16'b0, tl_major, tl_minor}, bad: 1'b0};
  end

  assign accept = bus.cfg_rd_valid && rd_ready_q && (state_q == ST_IDLE);

  // Next state and registered outputs; ready/valid are precomputed from the next state.
  always_comb begin
    state_d = state_q;
    rd_dw_d = rd_dw_q;
    rsp_d   = rsp_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_DECODE;
          rd_dw_d = bus.cfg_rd_addr[ADDR_W-1:2];
        end
      end
      ST_DECODE: begin
        state_d = ST_RESP;
        rsp_d   = rd_word;
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    rd_ready_d  = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rd_dw_q     <= '0;
      rd_ready_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      state_q     <= state_d;
      rd_dw_q     <= rd_dw_d;
      rd_ready_q  <= rd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign bus.cfg_rd_ready = rd_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_q.data;
  assign bus.rsp_bad      = rsp_q.bad;

endmodule

// File: tb/tb_cfg_ro_responder.sv
// Bench for cfg_ro_responder: vector table of writes/reads, response scoreboard,
// and hand sequences for back-pressure, write/read races and reset mid-read.
module tb_cfg_ro_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] bar0_size, bar1_size, bar2_size;
  logic        bar0_pf, bar1_pf, bar2_pf;
  logic [31:0] exp_rom_bar;
  logic [15:0] subsys_id, subsys_vendor_id;
  logic [63:0] dsn;
  logic [7:0]  tl_major, tl_minor;

  cfg_ro_responder_if bus ();

  cfg_ro_responder #(.DSN_BASE(12'h100), .OTL_BASE(12'h200)) dut (
    .clock            (clock),
    .reset            (reset),
    .bar0_size        (bar0_size),
    .bar1_size        (bar1_size),
    .bar2_size        (bar2_size),
    .bar0_pf          (bar0_pf),
    .bar1_pf          (bar1_pf),
    .bar2_pf          (bar2_pf),
    .exp_rom_bar      (exp_rom_bar),
    .subsys_id        (subsys_id),
    .subsys_vendor_id (subsys_vendor_id),
    .dsn              (dsn),
    .tl_major         (tl_major),
    .tl_minor         (tl_minor),
    .bus              (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic        bad;
    int          acc;
  } exp_t;

  typedef struct {
    logic        is_wr;
    logic [11:0] addr;
    logic [31:0] val;
    logic        bad;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   lat_done = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Response monitor: latency from accept and payload checked against the queue head.
  always @(negedge clock) begin
    if (reset) begin
      lat_done = 1'b0;
    end else if (bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_rsp: got rsp_valid=1 expected no response pending");
      end else begin
        if (!lat_done) begin
          check($sformatf("latency@%03h", exp_q[0].addr), 32'(cyc - exp_q[0].acc), 32'd2);
          lat_done = 1'b1;
        end
        if (bus.rsp_ready) begin
          exp_t e;
          e = exp_q.pop_front();
          check($sformatf("rsp_data@%03h", e.addr), bus.rsp_data, e.data);
          check($sformatf("rsp_bad@%03h", e.addr), 32'(bus.rsp_bad), 32'(e.bad));
          lat_done = 1'b0;
        end
      end
    end
  end

  task automatic cfg_write(input logic [11:0] a, input logic [31:0] d);
    bus.cfg_wr_valid = 1'b1;
    bus.cfg_wr_addr  = a;
    bus.cfg_wr_data  = d;
    tick();
    bus.cfg_wr_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got %0d responses pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // wr_phase 1: write in the accept cycle; 2: write in the cycle after accept.
  task automatic accept_rd(input logic [11:0] a, input logic [31:0] ed, input logic eb,
                           input int wr_phase, input logic [11:0] wa, input logic [31:0] wd,
                           input bit push);
    bit ok;
    ok = 1'b0;
    bus.cfg_rd_valid = 1'b1;
    bus.cfg_rd_addr  = a;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.cfg_rd_ready) begin
        ok = 1'b1;
        if (wr_phase == 1) begin
          bus.cfg_wr_valid = 1'b1;
          bus.cfg_wr_addr  = wa;
          bus.cfg_wr_data  = wd;
        end
        if (push) exp_q.push_back('{addr: a, data: ed, bad: eb, acc: cyc});
      end
      tick();
    end
    bus.cfg_rd_valid = 1'b0;
    bus.cfg_wr_valid = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept@%03h: got no cfg_rd_ready expected accept within 20 cycles", a);
    end
    if (wr_phase == 2) cfg_write(wa, wd);
  endtask

  task automatic do_read(input logic [11:0] a, input logic [31:0] ed, input logic eb);
    accept_rd(a, ed, eb, 0, 12'h0, 32'h0, 1'b1);
    drain($sformatf("drain@%03h", a));
  endtask

  function automatic vec_t wr(input logic [11:0] a, input logic [31:0] d);
    return '{is_wr: 1'b1, addr: a, val: d, bad: 1'b0};
  endfunction

  function automatic vec_t rd(input logic [11:0] a, input logic [31:0] d, input logic b);
    return '{is_wr: 1'b0, addr: a, val: d, bad: b};
  endfunction

  initial begin
    bar0_size = 64'hFFFF_FFFF_0000_0000;  bar0_pf = 1'b0;
    bar1_size = 64'hFFFF_FFFF_FFFF_FFFF;  bar1_pf = 1'b1;
    bar2_size = 64'hFFFF_FFFF_FFFF_F000;  bar2_pf = 1'b0;
    exp_rom_bar = 32'hFFFE_0001;
    subsys_id = 16'h0667;  subsys_vendor_id = 16'h1014;
    dsn = 64'hDEAD_BEEF_0123_4567;
    tl_major = 8'h03;  tl_minor = 8'h01;
    bus.cfg_wr_valid = 1'b0;  bus.cfg_wr_addr = '0;  bus.cfg_wr_data = '0;
    bus.cfg_rd_valid = 1'b0;  bus.cfg_rd_addr = '0;  bus.rsp_ready = 1'b1;

    vecs.push_back(wr(12'h010, 32'hFFFF_FFFF));
    vecs.push_back(wr(12'h014, 32'hFFFF_FFFF));
    vecs.push_back(rd(12'h010, 32'h0000_0004, 1'b0));
    vecs.push_back(rd(12'h014, 32'hFFFF_FFFF, 1'b0));
    vecs.push_back(rd(12'h012, 32'h0000_0004, 1'b0));
    vecs.push_back(rd(12'h02C, 32'h0667_1014, 1'b0));
    vecs.push_back(rd(12'h0C4, 32'h0000_0000, 1'b1));
    vecs.push_back(rd(12'h104, 32'h0123_4567, 1'b0));
    vecs.push_back(rd(12'h108, 32'hDEAD_BEEF, 1'b0));
    vecs.push_back(rd(12'h100, 32'h0000_0000, 1'b1));
    vecs.push_back(rd(12'h200, 32'h0000_0301, 1'b0));
    vecs.push_back(rd(12'h030, 32'hFFFE_0001, 1'b0));
    vecs.push_back(rd(12'h018, 32'h0000_000C, 1'b0));
    vecs.push_back(wr(12'h020, 32'hABCD_1234));
    vecs.push_back(rd(12'h020, 32'hABCD_1004, 1'b0));
    vecs.push_back(wr(12'h024, 32'h5555_AAAA));
    vecs.push_back(rd(12'h024, 32'h5555_AAAA, 1'b0));
    vecs.push_back(wr(12'h028, 32'h1111_2222));
    vecs.push_back(rd(12'h028, 32'h0000_0000, 1'b1));
    vecs.push_back(wr(12'h02C, 32'h1234_4321));
    vecs.push_back(rd(12'h02C, 32'h0667_1014, 1'b0));
    vecs.push_back(rd(12'h01C, 32'h0000_0000, 1'b0));

    tick();
    tick();
    check("reset_rd_ready", 32'(bus.cfg_rd_ready), 32'd0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_data", bus.rsp_data, 32'd0);
    check("reset_rsp_bad", 32'(bus.rsp_bad), 32'd0);
    reset = 1'b0;
    tick();
    check("rd_ready_after_reset", 32'(bus.cfg_rd_ready), 32'd1);

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) cfg_write(vecs[i].addr, vecs[i].val);
      else               do_read(vecs[i].addr, vecs[i].val, vecs[i].bad);
    end

    // Back-pressure: response held for 5 cycles while the same BAR is rewritten.
    bus.rsp_ready = 1'b0;
    accept_rd(12'h014, 32'hFFFF_FFFF, 1'b0, 0, 12'h0, 32'h0, 1'b1);
    tick();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("hold_valid%0d", k), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("hold_data%0d", k), bus.rsp_data, 32'hFFFF_FFFF);
      check($sformatf("hold_rd_ready%0d", k), 32'(bus.cfg_rd_ready), 32'd0);
      if (k == 1) cfg_write(12'h014, 32'h0000_0000);
      else        tick();
    end
    bus.rsp_ready = 1'b1;
    drain("drain_hold");
    do_read(12'h014, 32'h0000_0000, 1'b0);

    // Write in the accept cycle is visible; a write one cycle later is not.
    accept_rd(12'h01C, 32'h1234_5678, 1'b0, 1, 12'h01C, 32'h1234_5678, 1'b1);
    drain("drain_wr_accept");
    accept_rd(12'h01C, 32'h1234_5678, 1'b0, 2, 12'h01C, 32'h9999_9999, 1'b1);
    drain("drain_wr_decode");
    do_read(12'h01C, 32'h9999_9999, 1'b0);

    // Reset while the read sits in DECODE drops the response and clears the BARs.
    accept_rd(12'h024, 32'h0, 1'b0, 0, 12'h0, 32'h0, 1'b0);
    reset = 1'b1;
    tick();
    check("rst_dec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_dec_rd_ready", 32'(bus.cfg_rd_ready), 32'd0);
    check("rst_dec_rsp_data", bus.rsp_data, 32'd0);
    tick();
    reset = 1'b0;
    check("rel_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    check("rel_rd_ready", 32'(bus.cfg_rd_ready), 32'd1);
    check("rel_rsp_valid2", 32'(bus.rsp_valid), 32'd0);
    do_read(12'h010, 32'h0000_0004, 1'b0);
    do_read(12'h014, 32'h0000_0000, 1'b0);
    do_read(12'h018, 32'h0000_000C, 1'b0);
    do_read(12'h01C, 32'h0000_0000, 1'b0);
    do_read(12'h020, 32'h0000_0004, 1'b0);
    do_read(12'h024, 32'h0000_0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
